dna_pattern_search: RTL and testbench

- Parametrised successor to the lab5 DNA search FSM.
- Streams a DNA sequence of 2-bit nucleotides from a synchronous read memory, with 1-cycle read latency.
- Compares a sliding window against a programmable pattern of PAT_LEN symbols.
- Reports found/not-found, the index of the first match, and an error for an illegal length.
- Sits between the lab top-level control FSM and the sequence RAM.

---
 rtl/dna_pattern_search.sv | 208 ++++++++++++++++++++
 tb/tb_dna_pattern_search.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dna_pattern_search.sv
// Streams 2-bit nucleotides from a 1-cycle-latency RAM and matches a sliding PAT_LEN-symbol window.
// Optional build macro DNA_COUNT_ALL_EN: scan the whole sequence and count every (overlapping) match.
module dna_pattern_search #(
    parameter int ADDR_W  = 16,
    parameter int SYM_W   = 2,
    parameter int PAT_LEN = 4,
    parameter int MAX_LEN = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ready,
    input  logic [ADDR_W-1:0]        dna_length,
    input  logic [PAT_LEN*SYM_W-1:0] pattern,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [SYM_W-1:0]         mem_data,
    output logic                     done,
    output logic                     found_it,
    output logic                     error,
    output logic [ADDR_W-1:0]        match_index,
    output logic [ADDR_W-1:0]        match_count
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);

`ifdef DNA_COUNT_ALL_EN
    localparam bit COUNT_ALL = 1'b1;
`else
    localparam bit COUNT_ALL = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE,
        ERR
    } state_t;

    typedef logic [PAT_LEN-1:0][SYM_W-1:0] window_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    window_t             pat_q, pat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rd_vld_q, rd_vld_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    window_t             win_q, win_d;
    window_t             win_shift;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                win_vld_q, win_vld_d;
    logic [ADDR_W-1:0]   win_addr_q, win_addr_d;
    logic                done_pend_q, done_pend_d;
    logic                found_q, found_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    logic                busy;
    logic                len_bad;
    logic                match;
    logic                win_last;
    logic [ADDR_W-1:0]   match_start;

    // Oldest symbol sits at position 0 so the window lines up with the pattern layout.
    genvar gi;
    generate
        for (gi = 0; gi < PAT_LEN; gi++) begin : g_win
            if (gi == PAT_LEN - 1) begin : g_newest
                assign win_shift[gi] = mem_data;
            end else begin : g_older
                assign win_shift[gi] = win_q[gi+1];
            end
        end
    endgenerate

    assign busy        = (state_q == SCAN) || (state_q == DRAIN);
    assign len_bad     = (dna_length < ADDR_W'(PAT_LEN)) || (dna_length > ADDR_W'(MAX_LEN));
    assign match       = win_vld_q && (fill_q == FILL_W'(PAT_LEN)) && (win_q == pat_q);
    assign win_last    = win_vld_q && (win_addr_q == len_q - ADDR_W'(1));
    assign match_start = win_addr_q - ADDR_W'(PAT_LEN - 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            pat_q       <= '0;
            addr_q      <= '0;
            rd_vld_q    <= 1'b0;
            rd_addr_q   <= '0;
            win_q       <= '0;
            fill_q      <= '0;
            win_vld_q   <= 1'b0;
            win_addr_q  <= '0;
            done_pend_q <= 1'b0;
            found_q     <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pat_q       <= pat_d;
            addr_q      <= addr_d;
            rd_vld_q    <= rd_vld_d;
            rd_addr_q   <= rd_addr_d;
            win_q       <= win_d;
            fill_q      <= fill_d;
            win_vld_q   <= win_vld_d;
            win_addr_q  <= win_addr_d;
            done_pend_q <= done_pend_d;
            found_q     <= found_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pat_d       = pat_q;
        addr_d      = addr_q;
        rd_vld_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        win_d       = win_q;
        fill_d      = fill_q;
        win_vld_d   = 1'b0;
        win_addr_d  = win_addr_q;
        done_pend_d = 1'b0;
        found_d     = found_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;

        // Data path only runs while a scan is live; stragglers after DONE are dropped.
        if (busy) begin
            rd_vld_d  = (state_q == SCAN);
            rd_addr_d = addr_q;
            if (rd_vld_q) begin
                win_d      = win_shift;
                win_vld_d  = 1'b1;
                win_addr_d = rd_addr_q;
                if (fill_q != FILL_W'(PAT_LEN)) begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
            if (match) begin
                found_d = 1'b1;
                if (!found_q) begin
                    idx_d = match_start;
                end
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            if (win_last) begin
                done_pend_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (ready) begin
                    len_d      = dna_length;
                    pat_d      = pattern;
                    found_d    = 1'b0;
                    idx_d      = '0;
                    cnt_d      = '0;
                    win_d      = '0;
                    fill_d     = '0;
                    win_addr_d = '0;
                    rd_addr_d  = '0;
                    addr_d     = '0;
                    state_d    = len_bad ? ERR : SCAN;
                end
            end
            SCAN: begin
                addr_d = addr_q + ADDR_W'(1);
                if (addr_q == len_q - ADDR_W'(1)) begin
                    state_d = DRAIN;
                end
                if (match && !COUNT_ALL) begin
                    state_d = DONE;
                end
            end
            DRAIN: begin
                // Stay until the final window has been compared, then settle one cycle later.
                if ((match && !COUNT_ALL) || done_pend_q) begin
                    state_d = DONE;
                end
            end
            DONE, ERR: begin
                if (!ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_rd      = (state_q == SCAN);
    assign mem_addr    = addr_q;
    assign done        = (state_q == DONE) || (state_q == ERR);
    assign error       = (state_q == ERR);
    assign found_it    = found_q;
    assign match_index = idx_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_dna_pattern_search.sv
// Directed table-driven bench for dna_pattern_search with a 1-cycle synchronous read memory.
// Expected values follow the DNA_COUNT_ALL_EN build macro when it is defined.
module tb_dna_pattern_search;

    localparam int ADDR_W  = 16;
    localparam int SYM_W   = 2;
    localparam int PAT_LEN = 4;
    localparam int MAX_LEN = 1024;

`ifdef DNA_COUNT_ALL_EN
    localparam bit CA = 1'b1;
`else
    localparam bit CA = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     ready;
    logic [ADDR_W-1:0]        dna_length;
    logic [PAT_LEN*SYM_W-1:0] pattern;
    logic                     mem_rd;
    logic [ADDR_W-1:0]        mem_addr;
    logic [SYM_W-1:0]         mem_data;
    logic                     done;
    logic                     found_it;
    logic                     error;
    logic [ADDR_W-1:0]        match_index;
    logic [ADDR_W-1:0]        match_count;

    logic [SYM_W-1:0] mem [0:MAX_LEN-1];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd && mem_addr < ADDR_W'(MAX_LEN)) begin
            mem_data <= mem[mem_addr[9:0]];
        end
    end

    dna_pattern_search #(
        .ADDR_W (ADDR_W),
        .SYM_W  (SYM_W),
        .PAT_LEN(PAT_LEN),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .ready      (ready),
        .dna_length (dna_length),
        .pattern    (pattern),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .done       (done),
        .found_it   (found_it),
        .error      (error),
        .match_index(match_index),
        .match_count(match_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] seq;
        int          len;
        logic [7:0]  pat;
        int          exp_edge;
        int          exp_found;
        int          exp_idx;
        int          exp_cnt;
        int          exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] seq, input int len,
                                input logic [7:0] pat, input int e, input int f,
                                input int idx, input int cnt, input int err);
        vec_t v;
        v.name = name; v.seq = seq; v.len = len; v.pat = pat;
        v.exp_edge = e; v.exp_found = f; v.exp_idx = idx; v.exp_cnt = cnt; v.exp_err = err;
        return v;
    endfunction

    // Symbols 0..15 come from seq; everything above is T.
    task automatic load(input logic [31:0] seq);
        for (int i = 0; i < MAX_LEN; i++) begin
            mem[i] = (i < 16) ? seq[2*i +: 2] : 2'b11;
        end
    endtask

    task automatic run(input vec_t v);
        int   e;
        int   rd;
        int   exp_rd;
        bit   addr_ok;
        bit   stable;
        load(v.seq);
        @(negedge clk);
        dna_length = v.len[15:0];
        pattern    = v.pat;
        ready      = 1'b1;
        @(posedge clk);
        #1;
        dna_length = 16'hFFFF;
        pattern    = ~v.pat;
        e = 0; rd = 0; addr_ok = 1'b1;
        while (!done && e < 2000) begin
            if (mem_rd) begin
                if (mem_addr != rd[15:0]) addr_ok = 1'b0;
                rd++;
            end
            @(posedge clk);
            #1;
            e++;
        end
        exp_rd = v.exp_err ? 0 : ((v.exp_edge < v.len) ? v.exp_edge : v.len);
        chk($sformatf("%s done", v.name), int'(done), 1);
        chk($sformatf("%s done_edge", v.name), e, v.exp_edge);
        chk($sformatf("%s found_it", v.name), int'(found_it), v.exp_found);
        chk($sformatf("%s match_index", v.name), int'(match_index), v.exp_idx);
        chk($sformatf("%s match_count", v.name), int'(match_count), v.exp_cnt);
        chk($sformatf("%s error", v.name), int'(error), v.exp_err);
        chk($sformatf("%s read_cycles", v.name), rd, exp_rd);
        chk($sformatf("%s read_addrs", v.name), int'(addr_ok), 1);
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!done || mem_rd || int'(found_it) != v.exp_found || int'(match_index) != v.exp_idx
                || int'(match_count) != v.exp_cnt || int'(error) != v.exp_err) stable = 1'b0;
        end
        chk($sformatf("%s hold_ready", v.name), int'(stable), 1);
        @(negedge clk);
        ready = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("%s idle_done", v.name), int'(done), 0);
        chk($sformatf("%s idle_error", v.name), int'(error), 0);
        if (v.exp_err != 0) chk($sformatf("%s idle_found", v.name), int'(found_it), 0);
        $display("vector %-12s len=%0d pat=%h edge=%0d found=%0d idx=%0d cnt=%0d err=%0d reads=%0d",
                 v.name, v.len, v.pat, e, found_it, match_index, match_count, error, rd);
    endtask

    initial begin
        // Patterns/sequences: symbol i at bits [2i+1:2i]; A=0 C=1 G=2 T=3.
        vecs[0]  = mk("ggca",       32'h0000_FF1A, 8,    8'hC6, CA ? 11 : 7,  1, 1, 1,          0);
        vecs[1]  = mk("acgt_x2",    32'h0000_E4E4, 8,    8'hE4, CA ? 11 : 6,  1, 0, CA ? 2 : 1, 0);
        vecs[2]  = mk("aaaaa",      32'h0000_0000, 5,    8'h00, CA ? 8 : 6,   1, 0, CA ? 2 : 1, 0);
        vecs[3]  = mk("tttt_miss",  32'hFFFF_FFFF, 8,    8'hE4, 11,           0, 0, 0,          0);
        vecs[4]  = mk("len_eq_pat", 32'h0000_E4E4, 4,    8'hE4, CA ? 7 : 6,   1, 0, 1,          0);
        vecs[5]  = mk("match_end",  32'h0000_E4FF, 8,    8'hE4, CA ? 11 : 10, 1, 4, 1,          0);
        vecs[6]  = mk("cgta",       32'h0000_E4E4, 8,    8'h39, CA ? 11 : 7,  1, 1, 1,          0);
        vecs[7]  = mk("a_overlap8", 32'h0000_0000, 8,    8'h00, CA ? 11 : 6,  1, 0, CA ? 5 : 1, 0);
        vecs[8]  = mk("len_short",  32'h0000_E4E4, 3,    8'hE4, 0,            0, 0, 0,          1);
        vecs[9]  = mk("len_max",    32'hFFFF_FFFF, 1024, 8'hAA, 1027,         0, 0, 0,          0);
        vecs[10] = mk("len_over",   32'h0000_E4E4, 1025, 8'hE4, 0,            0, 0, 0,          1);
        vecs[11] = mk("len_zero",   32'h0000_E4E4, 0,    8'hE4, 0,            0, 0, 0,          1);

        reset = 1'b1; ready = 1'b0; dna_length = '0; pattern = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset done", int'(done), 0);
        chk("reset found_it", int'(found_it), 0);
        chk("reset error", int'(error), 0);
        chk("reset mem_rd", int'(mem_rd), 0);
        chk("reset mem_addr", int'(mem_addr), 0);
        chk("reset match_index", int'(match_index), 0);
        chk("reset match_count", int'(match_count), 0);
        $display("reset: done=%0d found=%0d err=%0d rd=%0d", done, found_it, error, mem_rd);
        @(negedge clk);
        reset = 1'b0;

        // Abort a scan with reset three cycles after it starts.
        load(32'h0000_E4E4);
        @(negedge clk);
        dna_length = 16'd8; pattern = 8'hE4; ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midscan mem_rd_before", int'(mem_rd), 1);
        reset = 1'b1; ready = 1'b0;
        @(posedge clk);
        #1;
        chk("midscan mem_rd", int'(mem_rd), 0);
        chk("midscan mem_addr", int'(mem_addr), 0);
        chk("midscan done", int'(done), 0);
        chk("midscan found_it", int'(found_it), 0);
        chk("midscan match_count", int'(match_count), 0);
        $display("midscan reset: rd=%0d addr=%0d done=%0d", mem_rd, mem_addr, done);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset idle mem_rd", int'(mem_rd), 0);

        for (int i = 0; i < 12; i++) begin
            run(vecs[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
